// File: rtl/mu0_pkg.sv
// mu0_pkg: shared types and constants for the MU0 phase sequencer.
//   state_t            - sequencer state encoding (3-bit)
//   OP_LDA..OP_STP     - legal MU0 opcodes (IR[15:12]); 8..15 are illegal
//   alu_op_t           - ALU function select driven with acc_load
//   DEFAULT_EXTRA_MASK - opcodes that spend an EXEC2 cycle on the ACC write
//   is_mem_read/alu_for - decode helpers shared by EXEC1 and EXEC2
package mu0_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC1 = 3'd2,
        ST_EXEC2 = 3'd3,
        ST_HALT  = 3'd4,
        ST_FAULT = 3'd5
    } state_t;

    localparam logic [3:0] OP_LDA = 4'd0;
    localparam logic [3:0] OP_STO = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_JMP = 4'd4;
    localparam logic [3:0] OP_JGE = 4'd5;
    localparam logic [3:0] OP_JNE = 4'd6;
    localparam logic [3:0] OP_STP = 4'd7;

    // Encoding 2'b11 is reserved and never driven.
    typedef enum logic [1:0] {
        ALU_PASS = 2'b00,
        ALU_ADD  = 2'b01,
        ALU_SUB  = 2'b10
    } alu_op_t;

    localparam logic [15:0] DEFAULT_EXTRA_MASK = 16'h000C;

    // Opcodes that read memory and then write the accumulator.
    function automatic logic is_mem_read(input logic [3:0] op);
        return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB);
    endfunction

    // ALU function for the accumulator write of a read-class opcode.
    function automatic alu_op_t alu_for(input logic [3:0] op);
        case (op)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            default: return ALU_PASS;
        endcase
    endfunction

endpackage

// File: rtl/mu0_phase_sequencer_if.sv
// mu0_phase_sequencer_if: memory request handshake between the sequencer
// (master) and the memory port (slave).
//   mem_req  - access requested this cycle
//   mem_we   - access is a write (STO)
//   addr_sel - address source: 0 = PC, 1 = IR[11:0]
//   mem_ack  - memory completes the current access this cycle
// Handshake: an access is in flight for every cycle mem_req is high; it
// completes in the cycle mem_req and mem_ack are both high. mem_ack while
// mem_req is low carries no meaning and is ignored.
interface mu0_phase_sequencer_if;
    logic mem_req;
    logic mem_we;
    logic addr_sel;
    logic mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output addr_sel,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  addr_sel,
        output mem_ack
    );
endinterface

// File: rtl/mu0_wait_timer.sv
// mu0_wait_timer: counts wait cycles of the current memory access.
//   clk, rst_n - clock, asynchronous active-low reset
//   clear      - restart from zero (state change); wins over enable
//   enable     - one more cycle spent waiting for mem_ack
//   expired    - count has reached MAX_WAIT (never asserted if MAX_WAIT == 0)
module mu0_wait_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // Keep at least one bit so MAX_WAIT == 0 still elaborates.
    localparam int W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [W-1:0] LIMIT = W'(MAX_WAIT);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired && (MAX_WAIT > 0)) begin
            // Holds at the limit; the sequencer leaves the state anyway.
            count <= count + 1'b1;
        end
    end

    assign expired = (MAX_WAIT > 0) && (count == LIMIT);

endmodule

// File: rtl/mu0_phase_sequencer.sv
// mu0_phase_sequencer: registered control FSM sequencing the MU0 core
// through FETCH / EXEC1 / EXEC2, with wait states, access timeout, STP halt
// and illegal-opcode fault.
//   clk, rst_n        - clock, asynchronous active-low reset
//   boot              - run enable, sampled at instruction boundaries
//   ir_opcode         - IR[15:12], valid in EXEC1/EXEC2
//   acc_zero, acc_neg - accumulator flags for JNE / JGE
//   mem               - memory handshake (master side)
//   ir_load, pc_inc, pc_load, acc_load, alu_op - datapath strobes
//   fetch, exec1, exec2, halted, fault - Moore state flags
//   state_dbg         - raw state register for observation
module mu0_phase_sequencer
    import mu0_pkg::*;
#(
    parameter int          MAX_WAIT   = 15,
    parameter logic [15:0] EXTRA_MASK = DEFAULT_EXTRA_MASK
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  boot,
    input  logic [3:0]            ir_opcode,
    input  logic                  acc_zero,
    input  logic                  acc_neg,
    mu0_phase_sequencer_if.master mem,
    output logic                  ir_load,
    output logic                  pc_inc,
    output logic                  pc_load,
    output logic                  acc_load,
    output logic [1:0]            alu_op,
    output logic                  fetch,
    output logic                  exec1,
    output logic                  exec2,
    output logic                  halted,
    output logic                  fault,
    output state_t                state_dbg
);

    state_t  state;
    state_t  state_next;
    state_t  boundary;
    logic    req;
    logic    we;
    logic    asel;
    alu_op_t alu_sel;
    logic    timed_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req        = 1'b0;
        we         = 1'b0;
        asel       = 1'b0;
        ir_load    = 1'b0;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        acc_load   = 1'b0;
        alu_sel    = ALU_PASS;
        // Every instruction end goes here: back to FETCH, or park in IDLE
        // when the core has been told to stop.
        boundary   = boot ? ST_FETCH : ST_IDLE;

        case (state)
            ST_IDLE: begin
                if (boot) begin
                    state_next = ST_FETCH;
                end
            end

            ST_FETCH: begin
                req = 1'b1;
                if (mem.mem_ack) begin
                    ir_load    = 1'b1;
                    pc_inc     = 1'b1;
                    state_next = ST_EXEC1;
                end else if (timed_out) begin
                    state_next = ST_FAULT;
                end
            end

            ST_EXEC1: begin
                case (ir_opcode)
                    OP_LDA, OP_ADD, OP_SUB: begin
                        req  = 1'b1;
                        asel = 1'b1;
                        if (mem.mem_ack) begin
                            if (EXTRA_MASK[ir_opcode]) begin
                                // ACC write deferred to EXEC2.
                                state_next = ST_EXEC2;
                            end else begin
                                acc_load   = 1'b1;
                                alu_sel    = alu_for(ir_opcode);
                                state_next = boundary;
                            end
                        end else if (timed_out) begin
                            state_next = ST_FAULT;
                        end
                    end
                    OP_STO: begin
                        req  = 1'b1;
                        we   = 1'b1;
                        asel = 1'b1;
                        if (mem.mem_ack) begin
                            state_next = boundary;
                        end else if (timed_out) begin
                            state_next = ST_FAULT;
                        end
                    end
                    OP_JMP: begin
                        pc_load    = 1'b1;
                        state_next = boundary;
                    end
                    OP_JGE: begin
                        pc_load    = ~acc_neg;
                        state_next = boundary;
                    end
                    OP_JNE: begin
                        pc_load    = ~acc_zero;
                        state_next = boundary;
                    end
                    OP_STP: begin
                        state_next = ST_HALT;
                    end
                    default: begin
                        state_next = ST_FAULT;
                    end
                endcase
            end

            ST_EXEC2: begin
                acc_load   = 1'b1;
                alu_sel    = is_mem_read(ir_opcode) ? alu_for(ir_opcode) : ALU_PASS;
                state_next = boundary;
            end

            ST_HALT: begin
                // Leaving HALT only through boot=0 makes the next run need a
                // fresh 0->1 edge on boot.
                if (!boot) begin
                    state_next = ST_IDLE;
                end
            end

            ST_FAULT: begin
                state_next = ST_FAULT;
            end

            default: begin
                state_next = ST_FAULT;
            end
        endcase
    end

    mu0_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state_next != state),
        .enable  (req && !mem.mem_ack),
        .expired (timed_out)
    );

    assign mem.mem_req  = req;
    assign mem.mem_we   = we;
    assign mem.addr_sel = asel;
    assign alu_op       = alu_sel;

    assign fetch     = (state == ST_FETCH);
    assign exec1     = (state == ST_EXEC1);
    assign exec2     = (state == ST_EXEC2);
    assign halted    = (state == ST_HALT);
    assign fault     = (state == ST_FAULT);
    assign state_dbg = state;

endmodule
